// File: rtl/mem_bus_access_pkg.sv
// rtl/mem_bus_access_pkg.sv - op codes, exception codes and state encoding for the MEM-stage bus engine
package mem_bus_access_pkg;

   localparam int ALU_OP_W = 8;
   typedef logic [ALU_OP_W-1:0] alu_op_t;

   localparam alu_op_t EXE_LB_OP  = 8'b11100000;
   localparam alu_op_t EXE_LBU_OP = 8'b11100100;
   localparam alu_op_t EXE_LH_OP  = 8'b11100001;
   localparam alu_op_t EXE_LHU_OP = 8'b11100101;
   localparam alu_op_t EXE_LW_OP  = 8'b11100011;
   localparam alu_op_t EXE_LL_OP  = 8'b11110000;
   localparam alu_op_t EXE_SB_OP  = 8'b11101000;
   localparam alu_op_t EXE_SH_OP  = 8'b11101001;
   localparam alu_op_t EXE_SW_OP  = 8'b11101011;
   localparam alu_op_t EXE_SC_OP  = 8'b11111000;

   localparam logic [1:0] MEM_EXC_NONE    = 2'b00;
   localparam logic [1:0] MEM_EXC_ADEL    = 2'b01;
   localparam logic [1:0] MEM_EXC_ADES    = 2'b10;
   localparam logic [1:0] MEM_EXC_BUS_ERR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_BUSY  = 2'b01,
      S_DONE  = 2'b10,
      S_DRAIN = 2'b11
   } state_t;

   function automatic logic is_load(input alu_op_t op);
      return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
             (op == EXE_LHU_OP) || (op == EXE_LW_OP) || (op == EXE_LL_OP);
   endfunction

   function automatic logic is_store(input alu_op_t op);
      return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP) || (op == EXE_SC_OP);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane select, store replication, load extension and alignment check
module mem_lane_align
   import mem_bus_access_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  alu_op_t     op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata_in,
   input  logic [31:0] rdata_in,
   output logic [3:0]  sel,
   output logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        misalign
);

   logic [1:0]  byte_lane;
   logic        hi_half;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   // Big-endian puts address 0 in the most significant lane.
   assign byte_lane = BIG_ENDIAN ? ~addr_lo : addr_lo;
   assign hi_half   = addr_lo[1] ^ BIG_ENDIAN;
   assign byte_val  = rdata_in[{byte_lane, 3'b000} +: 8];
   assign half_val  = hi_half ? rdata_in[31:16] : rdata_in[15:0];

   // Per-op lane decode; non-memory ops produce all zeros.
   always_comb begin
      sel      = 4'b0000;
      wdata    = '0;
      rdata    = '0;
      misalign = 1'b0;
      case (op)
         EXE_LB_OP: begin
            sel   = 4'b0001 << byte_lane;
            rdata = {{24{byte_val[7]}}, byte_val};
         end
         EXE_LBU_OP: begin
            sel   = 4'b0001 << byte_lane;
            rdata = {24'd0, byte_val};
         end
         EXE_SB_OP: begin
            sel   = 4'b0001 << byte_lane;
            wdata = {4{wdata_in[7:0]}};
         end
         EXE_LH_OP: begin
            sel      = hi_half ? 4'b1100 : 4'b0011;
            rdata    = {{16{half_val[15]}}, half_val};
            misalign = addr_lo[0];
         end
         EXE_LHU_OP: begin
            sel      = hi_half ? 4'b1100 : 4'b0011;
            rdata    = {16'd0, half_val};
            misalign = addr_lo[0];
         end
         EXE_SH_OP: begin
            sel      = hi_half ? 4'b1100 : 4'b0011;
            wdata    = {2{wdata_in[15:0]}};
            misalign = addr_lo[0];
         end
         EXE_LW_OP, EXE_LL_OP: begin
            sel      = 4'b1111;
            rdata    = rdata_in;
            misalign = |addr_lo;
         end
         EXE_SW_OP, EXE_SC_OP: begin
            sel      = 4'b1111;
            wdata    = wdata_in;
            misalign = |addr_lo;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_bus_access.sv
// rtl/mem_bus_access.sv - multi-cycle MEM-stage load/store bus master with LL/SC link bit
module mem_bus_access
   import mem_bus_access_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1,
   parameter int WAIT_MAX   = 255,
   parameter int CNT_W      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        flush_i,
   input  logic        llclr_i,
   input  alu_op_t     aluop_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] reg2_i,
   output logic        stallreq_o,
   output logic [31:0] rdata_o,
   output logic        rdata_valid_o,
   output logic [1:0]  exc_o,
   output logic [31:0] badvaddr_o,
   output logic        llbit_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic        bus_err_i,
   input  logic [31:0] bus_rdata_i
);

   state_t            state_q, state_d;
   alu_op_t           op_q;
   logic [31:0]       addr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       rdata_q;
   logic [1:0]        exc_q;
   logic              llbit_q;

   alu_op_t           cur_op;
   logic [1:0]        cur_lo;
   logic [3:0]        lane_sel;
   logic [31:0]       lane_wdata;
   logic [31:0]       lane_rdata;
   logic              misalign;
   logic              fault, sc_fail, start, timeout, bus_done;

   // In IDLE the decoder looks at the incoming op; afterwards at the latched one for load extension.
   assign cur_op = (state_q == S_IDLE) ? aluop_i : op_q;
   assign cur_lo = (state_q == S_IDLE) ? addr_i[1:0] : addr_q[1:0];

   mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
      .op       (cur_op),
      .addr_lo  (cur_lo),
      .wdata_in (reg2_i),
      .rdata_in (bus_rdata_i),
      .sel      (lane_sel),
      .wdata    (lane_wdata),
      .rdata    (lane_rdata),
      .misalign (misalign)
   );

   assign fault    = req_i && misalign;
   assign sc_fail  = req_i && (aluop_i == EXE_SC_OP) && !misalign && !llbit_q;
   assign start    = req_i && (is_load(aluop_i) || is_store(aluop_i)) && !misalign && !sc_fail && !flush_i;
   assign timeout  = (cnt_q == CNT_W'(WAIT_MAX - 1));
   assign bus_done = bus_ack_i || bus_err_i || timeout;
   assign llbit_o  = llbit_q;

   // Next-state and pipeline-facing outputs.
   always_comb begin
      state_d       = state_q;
      stallreq_o    = 1'b0;
      rdata_valid_o = 1'b0;
      rdata_o       = '0;
      exc_o         = MEM_EXC_NONE;
      badvaddr_o    = '0;
      case (state_q)
         S_IDLE: begin
            if (fault) begin
               exc_o      = is_store(aluop_i) ? MEM_EXC_ADES : MEM_EXC_ADEL;
               badvaddr_o = addr_i;
            end else if (sc_fail) begin
               rdata_valid_o = 1'b1;
            end else if (start) begin
               stallreq_o = 1'b1;
               state_d    = S_BUSY;
            end
         end
         S_BUSY: begin
            stallreq_o = 1'b1;
            if (flush_i)
               state_d = bus_done ? S_IDLE : S_DRAIN;
            else if (bus_done)
               state_d = S_DONE;
         end
         S_DONE: begin
            rdata_valid_o = is_load(op_q) || (op_q == EXE_SC_OP);
            rdata_o       = rdata_q;
            exc_o         = exc_q;
            badvaddr_o    = (exc_q != MEM_EXC_NONE) ? addr_q : '0;
            state_d       = S_IDLE;
         end
         S_DRAIN: begin
            stallreq_o = 1'b1;
            if (bus_done)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, wait counter, and the latched transaction/result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         rdata_q <= '0;
         exc_q   <= MEM_EXC_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= (state_q == S_BUSY || state_q == S_DRAIN) ? cnt_q + 1'b1 : '0;
         if (state_q == S_IDLE && start) begin
            op_q    <= aluop_i;
            addr_q  <= addr_i;
            rdata_q <= '0;
            exc_q   <= MEM_EXC_NONE;
         end else if (state_q == S_BUSY && !flush_i) begin
            // err beats ack; an ack in the last allowed cycle still beats the timeout
            if (bus_err_i || (!bus_ack_i && timeout))
               exc_q <= MEM_EXC_BUS_ERR;
            if (bus_ack_i && !bus_err_i)
               rdata_q <= (op_q == EXE_SC_OP) ? 32'd1 : lane_rdata;
         end
      end
   end

   // Registered bus request, held from start until the ack/err/timeout cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_sel_o   <= 4'b0000;
         bus_wdata_o <= '0;
      end else if (state_q == S_IDLE && start) begin
         bus_req_o   <= 1'b1;
         bus_we_o    <= is_store(aluop_i);
         bus_addr_o  <= {addr_i[31:2], 2'b00};
         bus_sel_o   <= lane_sel;
         bus_wdata_o <= lane_wdata;
      end else if ((state_q == S_BUSY || state_q == S_DRAIN) && bus_done) begin
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_sel_o   <= 4'b0000;
         bus_wdata_o <= '0;
      end
   end

   // Link bit: LL sets, successful SC clears, llclr always wins.
   always_ff @(posedge clk) begin
      if (rst)
         llbit_q <= 1'b0;
      else if (llclr_i)
         llbit_q <= 1'b0;
      else if (state_q == S_DONE && exc_q == MEM_EXC_NONE) begin
         if (op_q == EXE_LL_OP)
            llbit_q <= 1'b1;
         else if (op_q == EXE_SC_OP)
            llbit_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_bus_access.sv
// tb/tb_mem_bus_access.sv - scoreboard bench for the MEM-stage bus engine
module tb_mem_bus_access;
   import mem_bus_access_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        valid;
      logic [1:0]  exc;
      logic [31:0] bad;
   } resp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] cycles;
   } bus_t;

   logic        clk, rst, req_i, flush_i, llclr_i;
   alu_op_t     aluop_i;
   logic [31:0] addr_i, reg2_i;
   logic        stallreq_o, rdata_valid_o, llbit_o;
   logic [31:0] rdata_o, badvaddr_o;
   logic [1:0]  exc_o;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_sel_o;
   logic        bus_ack_i, bus_err_i;
   logic [31:0] bus_rdata_i;

   int    vectors = 0;
   int    miscompares = 0;
   bit    mon_en = 0;
   resp_t exp_resp[$];
   bus_t  exp_bus[$];

   mem_bus_access #(.BIG_ENDIAN(1'b1), .WAIT_MAX(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .flush_i(flush_i), .llclr_i(llclr_i),
      .aluop_i(aluop_i), .addr_i(addr_i), .reg2_i(reg2_i),
      .stallreq_o(stallreq_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
      .exc_o(exc_o), .badvaddr_o(badvaddr_o), .llbit_o(llbit_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
      .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic exp_r(input logic [31:0] rdata, input logic valid, input logic [1:0] exc, input logic [31:0] bad);
      exp_resp.push_back('{rdata: rdata, valid: valid, exc: exc, bad: bad});
   endtask

   task automatic exp_b(input logic [31:0] addr, input logic [3:0] sel, input logic we,
                        input logic [31:0] wdata, input int cycles);
      exp_bus.push_back('{addr: addr, sel: sel, we: we, wdata: wdata, cycles: cycles});
   endtask

   // One instruction in MEM: cycle n=0 is the issue cycle, n>=1 follow it.
   task automatic run_op(input string name, input alu_op_t op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rd, input int ack_at,
                         input bit err, input int flush_at, input int rst_at, input int exp_stalls);
      int stalls;
      bit done;
      stalls = 0;
      done   = 0;
      @(posedge clk); #1;
      aluop_i = op; addr_i = addr; reg2_i = data; bus_rdata_i = rd; req_i = 1'b1;
      for (int n = 0; n < 40 && !done; n++) begin
         if (n > 0) begin
            @(posedge clk); #1;
            req_i = 1'b0;
         end
         bus_ack_i = (n == ack_at);
         bus_err_i = err && (n == ack_at);
         flush_i   = (n == flush_at);
         rst       = (n == rst_at);
         @(negedge clk);
         if (stallreq_o) stalls++;
         else done = 1;
      end
      #1;
      req_i = 1'b0; bus_ack_i = 1'b0; bus_err_i = 1'b0; flush_i = 1'b0; rst = 1'b0;
      chk({name, "_completes"}, {31'd0, done}, 32'd1);
      chk({name, "_stall_cycles"}, stalls, exp_stalls);
      repeat (2) @(posedge clk);
   endtask

   // Response monitor: every pipeline-visible result is matched against the scoreboard.
   initial begin
      resp_t r;
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (rdata_valid_o || exc_o != 2'b00) begin
            if (exp_resp.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_resp: got rdata %h valid %b exc %0d, required none", rdata_o, rdata_valid_o, exc_o);
            end else begin
               r = exp_resp.pop_front();
               chk("resp_rdata", rdata_o, r.rdata);
               chk("resp_valid", {31'd0, rdata_valid_o}, {31'd0, r.valid});
               chk("resp_exc", {30'd0, exc_o}, {30'd0, r.exc});
               chk("resp_badvaddr", badvaddr_o, r.bad);
            end
         end
      end
   end

   // Bus monitor: request fields checked every held cycle, duration checked on release.
   initial begin
      bus_t b;
      bit   prev_req;
      int   cyc;
      prev_req = 0;
      cyc = 0;
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (bus_req_o) begin
            if (exp_bus.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_bus: got addr %h sel %b, required no request", bus_addr_o, bus_sel_o);
            end else begin
               b = exp_bus[0];
               chk("bus_addr", bus_addr_o, b.addr);
               chk("bus_sel", {28'd0, bus_sel_o}, {28'd0, b.sel});
               chk("bus_we", {31'd0, bus_we_o}, {31'd0, b.we});
               chk("bus_wdata", bus_wdata_o, b.wdata);
            end
            cyc++;
         end else if (prev_req) begin
            if (exp_bus.size() != 0) begin
               b = exp_bus.pop_front();
               chk("bus_hold_cycles", cyc, b.cycles);
            end
            cyc = 0;
         end
         prev_req = bus_req_o;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_i = 1'b0; flush_i = 1'b0; llclr_i = 1'b0; aluop_i = '0;
      addr_i = '0; reg2_i = '0; bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
      chk("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
      chk("rst_bus_we", {31'd0, bus_we_o}, 32'd0);
      chk("rst_rdata_valid", {31'd0, rdata_valid_o}, 32'd0);
      chk("rst_llbit", {31'd0, llbit_o}, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_bus_addr", bus_addr_o, 32'd0);
      chk("rst_bus_wdata", bus_wdata_o, 32'd0);
      chk("rst_badvaddr", badvaddr_o, 32'd0);
      chk("rst_bus_sel", {28'd0, bus_sel_o}, 32'd0);
      chk("rst_exc", {30'd0, exc_o}, 32'd0);
      mon_en = 1'b1;

      // loads and stores across lanes (big-endian)
      exp_b(32'h100, 4'b0001, 1'b0, 32'h0, 1); exp_r(32'hFFFFFF80, 1'b1, 2'b00, 32'h0);
      run_op("lb", EXE_LB_OP, 32'h103, 32'h0, 32'h11223380, 1, 0, -1, -1, 2);
      exp_b(32'h200, 4'b0011, 1'b1, 32'hBEEFBEEF, 4);
      run_op("sh", EXE_SH_OP, 32'h202, 32'h0000BEEF, 32'h0, 4, 0, -1, -1, 5);
      exp_b(32'h100, 4'b0100, 1'b0, 32'h0, 1); exp_r(32'h000000A2, 1'b1, 2'b00, 32'h0);
      run_op("lbu", EXE_LBU_OP, 32'h101, 32'h0, 32'h11A23380, 1, 0, -1, -1, 2);
      exp_b(32'h200, 4'b1100, 1'b0, 32'h0, 2); exp_r(32'hFFFF8001, 1'b1, 2'b00, 32'h0);
      run_op("lh", EXE_LH_OP, 32'h200, 32'h0, 32'h80011234, 2, 0, -1, -1, 3);
      exp_b(32'h200, 4'b0011, 1'b0, 32'h0, 1); exp_r(32'h0000F234, 1'b1, 2'b00, 32'h0);
      run_op("lhu", EXE_LHU_OP, 32'h202, 32'h0, 32'h8001F234, 1, 0, -1, -1, 2);
      exp_b(32'h300, 4'b0100, 1'b1, 32'hA5A5A5A5, 1);
      run_op("sb", EXE_SB_OP, 32'h301, 32'h000000A5, 32'h0, 1, 0, -1, -1, 2);

      // alignment faults: no bus, no stall
      exp_r(32'h0, 1'b0, 2'b01, 32'h101);
      run_op("lw_adel", EXE_LW_OP, 32'h101, 32'h0, 32'h0, -1, 0, -1, -1, 0);
      exp_r(32'h0, 1'b0, 2'b10, 32'h102);
      run_op("sw_ades", EXE_SW_OP, 32'h102, 32'h0, 32'h0, -1, 0, -1, -1, 0);
      exp_r(32'h0, 1'b0, 2'b01, 32'h203);
      run_op("lh_adel", EXE_LH_OP, 32'h203, 32'h0, 32'h0, -1, 0, -1, -1, 0);
      run_op("nop", 8'h00, 32'h123, 32'h0, 32'h0, -1, 0, -1, -1, 0);

      // LL/SC success, then LL/SC with the link cleared in between
      exp_b(32'h40, 4'b1111, 1'b0, 32'h0, 1); exp_r(32'hCAFEF00D, 1'b1, 2'b00, 32'h0);
      run_op("ll", EXE_LL_OP, 32'h40, 32'h0, 32'hCAFEF00D, 1, 0, -1, -1, 2);
      chk("llbit_after_ll", {31'd0, llbit_o}, 32'd1);
      exp_b(32'h40, 4'b1111, 1'b1, 32'h12345678, 1); exp_r(32'h1, 1'b1, 2'b00, 32'h0);
      run_op("sc_ok", EXE_SC_OP, 32'h40, 32'h12345678, 32'h0, 1, 0, -1, -1, 2);
      chk("llbit_after_sc", {31'd0, llbit_o}, 32'd0);
      exp_b(32'h40, 4'b1111, 1'b0, 32'h0, 1); exp_r(32'h00000077, 1'b1, 2'b00, 32'h0);
      run_op("ll2", EXE_LL_OP, 32'h40, 32'h0, 32'h00000077, 1, 0, -1, -1, 2);
      chk("llbit_after_ll2", {31'd0, llbit_o}, 32'd1);
      @(posedge clk); #1 llclr_i = 1'b1;
      @(posedge clk); #1 llclr_i = 1'b0;
      @(negedge clk);
      chk("llbit_after_llclr", {31'd0, llbit_o}, 32'd0);
      exp_r(32'h0, 1'b1, 2'b00, 32'h0);
      run_op("sc_fail", EXE_SC_OP, 32'h40, 32'h12345678, 32'h0, -1, 0, -1, -1, 0);

      // timeout after WAIT_MAX=4 BUSY cycles, and err together with ack
      exp_b(32'h80, 4'b1111, 1'b0, 32'h0, 4); exp_r(32'h0, 1'b1, 2'b11, 32'h80);
      run_op("lw_timeout", EXE_LW_OP, 32'h80, 32'h0, 32'h0, -1, 0, -1, -1, 5);
      exp_b(32'h84, 4'b1111, 1'b1, 32'h000055AA, 2); exp_r(32'h0, 1'b0, 2'b11, 32'h84);
      run_op("sw_err_ack", EXE_SW_OP, 32'h84, 32'h000055AA, 32'h0, 2, 1, -1, -1, 3);

      // flush: drain until ack; flush with simultaneous ack; reset mid-BUSY
      exp_b(32'h300, 4'b1111, 1'b0, 32'h0, 3);
      run_op("lw_drain", EXE_LW_OP, 32'h300, 32'h0, 32'h99999999, 3, 0, 1, -1, 4);
      exp_b(32'h304, 4'b1111, 1'b0, 32'h0, 1);
      run_op("lw_flush_ack", EXE_LW_OP, 32'h304, 32'h0, 32'h88888888, 1, 0, 1, -1, 2);
      exp_b(32'h308, 4'b1111, 1'b0, 32'h0, 1);
      run_op("lw_rst", EXE_LW_OP, 32'h308, 32'h0, 32'h0, -1, 0, -1, 1, 2);

      repeat (4) @(posedge clk);
      chk("resp_queue_drained", exp_resp.size(), 32'd0);
      chk("bus_queue_drained", exp_bus.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_bus_access.md
# mem_bus_access

Multi-cycle load/store engine for the MEM stage of the 5-stage MIPS32 pipeline. It replaces the single-cycle, always-ready data-memory assumption with a request/acknowledge bus master that has wait states, a timeout, and bus-error reporting. It also detects address-alignment exceptions (AdEL/AdES) and owns the LL/SC link bit. It stalls the pipeline through `ctrl` while a transaction is outstanding and supports configurable byte-lane endianness.

## Interface
- `BIG_ENDIAN`, default 1: 1 maps addr[1:0]=00 to lane 3 (sel 4'b1000); 0 maps it to lane 0.
- `WAIT_MAX`, default 255: BUSY cycles without ack/err before a bus error is forced; range 1..65535.
- `CNT_W`, default 16: timeout counter width; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high (`RstEnable`).
- `req_i` in 1: valid instruction present in MEM.
- `flush_i` in 1: pipeline flush from `ctrl`.
- `llclr_i` in 1: clear link bit (eret / exception commit).
- `aluop_i` in `AluOpBus`: op; only LB, LBU, LH, LHU, LW, LL, SB, SH, SW, SC act; all others are no-ops.
- `addr_i` in 32: effective address.
- `reg2_i` in 32: store data.
- `stallreq_o` out 1: stall request to `ctrl`.
- `rdata_o` out 32: load result / SC status, extended.
- `rdata_valid_o` out 1: `rdata_o` is valid this cycle.
- `exc_o` out 2: 00 none, 01 AdEL, 10 AdES, 11 bus error.
- `badvaddr_o` out 32: faulting address, valid when `exc_o` is nonzero.
- `llbit_o` out 1: current link bit.
- `bus_req_o`, `bus_we_o` out 1: request, write enable.
- `bus_addr_o` out 32: word-aligned address ({addr[31:2],2'b00}).
- `bus_sel_o` out 4: byte enables.
- `bus_wdata_o` out 32: lane-replicated store data.
- `bus_ack_i`, `bus_err_i` in 1: completion, error; sampled only while `bus_req_o`=1.
- `bus_rdata_i` in 32: valid with `bus_ack_i`.

## Operation
- States: IDLE, BUSY, DONE, DRAIN.
- Alignment check in IDLE, combinational:
  - LH/LHU/SH require addr[0]=0.
  - LW/LL/SW/SC require addr[1:0]=0.
  - Loads report AdEL; stores report AdES.
  - Faulting ops issue no bus access and no stall. `exc_o` and `badvaddr_o` = `addr_i` for that cycle. Link bit is unchanged.
- SC with `llbit_o`=0: no bus access, no stall. `rdata_o`=0, `rdata_valid_o`=1 the same cycle.
- Start condition: `req_i` & active op & aligned & not (SC with llbit=0) & `flush_i`=0. In IDLE this asserts `stallreq_o` combinationally, latches op/addr/data/sel, and moves to BUSY.
- Lanes:
  - SB: data {4{reg2[7:0]}}, one-hot sel.
  - SH: data {2{reg2[15:0]}}, sel 1100/0011 per endianness.
  - SW/SC: sel 1111.
  - Loads: sign-extend for LB/LH, zero-extend for LBU/LHU.
- BUSY:
  - Drives `bus_req_o`=1, `stallreq_o`=1, counter increments.
  - `bus_ack_i` → capture the extended result, go DONE.
  - `bus_err_i`, or counter reaching WAIT_MAX → go DONE with `exc_o`=11 and `badvaddr_o`=latched address.
  - `flush_i` → DRAIN.
- DONE (one cycle):
  - `stallreq_o`=0, `rdata_valid_o`=1 for loads/SC; SC result is 1.
  - Link bit: LL sets it, successful SC clears it.
  - Returns to IDLE unconditionally. `req_i` in DONE is never treated as a new start.
- DRAIN: keeps `bus_req_o` and `stallreq_o` high until ack/err or timeout, then IDLE. Result is discarded, no exception, link bit unchanged.
- `llclr_i` clears the link bit in any state. It wins over a simultaneous LL set.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `bus_req_o`, `bus_we_o`, `stallreq_o` (absent `req_i`), `rdata_valid_o`, `llbit_o` = 0.
  - `rdata_o`, `bus_addr_o`, `bus_wdata_o`, `badvaddr_o` = 0.
  - `bus_sel_o` = 0000, `exc_o` = 00.
- `rst` mid-transaction returns to IDLE next edge and drops `bus_req_o`. The bus slave must tolerate an abandoned request.
- Bus rule: `bus_req_o`, `bus_addr_o`, `bus_sel_o`, `bus_we_o`, `bus_wdata_o` are registered and stable from assertion through the ack/err cycle. They deassert on the following edge. Back-to-back requests always have ≥1 idle cycle (the DONE cycle).
- Minimum latency: start cycle T0, BUSY T1 with ack at T1, DONE T2. Total stall is 2 cycles.
- Timeout: error forced at the end of the WAIT_MAX-th BUSY cycle.
- Simultaneous ack and err: err wins.
- Simultaneous `flush_i` and ack in BUSY: flush wins. The ack completes the transaction, go straight to IDLE, result discarded.

## Structure
- Op codes (`EXE_*_OP`) and `RstEnable` come from `defines.v`.
- Add `MemExcNone/AdEL/AdES/BusErr` and state encodings there.
- One combinational sub-module, `mem_lane_align`: `addr[1:0]`, op, and `BIG_ENDIAN` → sel, replicated wdata, extended rdata, misalign flag.

## Test plan
- LB with addr 0x103, bus_rdata 0x11223380, BIG_ENDIAN=1, ack on first BUSY cycle → sel 0001, rdata_o 0xFFFFFF80 in DONE, stall exactly 2 cycles.
- SH with addr 0x202, reg2 0x0000BEEF, ack after 3 wait cycles → bus_addr 0x200, sel 0011, wdata 0xBEEFBEEF held stable 4 cycles, stall 5 cycles.
- LW with addr 0x0101 → exc_o 01, badvaddr_o 0x101, no bus_req_o, no stall; SW with addr 0x0102 → exc_o 10.
- LL 0x40 (ack) then SC 0x40 → llbit_o 1, SC write occurs, rdata_o 1, llbit_o 0. Repeat with llclr_i pulsed between → SC has no bus access and returns rdata_o 0.
- WAIT_MAX=4, no ack → exc_o 11 after 4 BUSY cycles. Separately, bus_err_i and bus_ack_i together → exc_o 11.
- flush_i during BUSY of LW, ack 2 cycles later → stays DRAIN, bus_req_o held, then IDLE with no rdata_valid_o. rst asserted mid-BUSY → bus_req_o 0 next cycle.
